// File: rtl/clock_enable_nco.sv
// ---------------------------------------------------------------------------
// clock_enable_nco
//
// Multi-channel numerically-controlled clock-enable generator, clocked by
// the PLL output. Each channel owns a phase accumulator whose carry-out
// produces a one-cycle enable strobe (tick) and toggles a square output
// (clk_out). Average tick rate is f_clk * inc / 2^ACC_W, so rates such as
// VDP, sound and I2S can be set at runtime instead of being restricted to
// power-of-two divisions of the PLL clock.
//
// Generation runs only after the PLL lock input has been synchronised and
// has stayed high for LOCK_WAIT cycles. Whenever generation stops, all
// accumulators are held at zero, so every channel restarts phase-aligned.
//
// Increments are retuned without glitches: a written value waits in a
// per-channel pending register and is adopted on that channel's next
// carry. If the channel is idle (not running, or increment zero), the
// pending value is adopted on the cycle after the write.
//
// Ports
//   clock_in  in   1       PLL output clock, sole clock of the block
//   reset     in   1       synchronous active-high reset
//   locked    in   1       PLL lock, asynchronous to clock_in
//   cfg_wr    in   1       one-cycle increment write strobe
//   cfg_chan  in   CH_W    target channel of the write
//   cfg_inc   in   ACC_W   new increment value
//   cfg_err   out  1       one-cycle pulse: write to a nonexistent channel
//   run       out  1       high while generation is active
//   tick      out  NUM_CH  per-channel one-cycle enable strobe
//   clk_out   out  NUM_CH  per-channel square wave, toggles on each tick
// ---------------------------------------------------------------------------
module clock_enable_nco #(
  parameter int NUM_CH    = 3,
  parameter int ACC_W     = 24,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {NUM_CH*ACC_W{1'b0}},
  parameter int LOCK_WAIT = 16,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              locked,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic              run,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam int CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             lock_meta;
  logic             lock_s;
  logic             go;
  logic             chan_ok;

  // Lock synchroniser: two flops bring the asynchronous PLL lock into the
  // clock_in domain.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
    end
  end

  // Lock qualification FSM: state register.
  // run is registered from the next state so that it equals (state == RUN).
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      run   <= (state_nx == RUN);
    end
  end

  // Lock qualification FSM: next state. Any drop of the synchronised lock
  // returns to WAIT_LOCK, and the full settle interval restarts on the next
  // rising lock.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
        end else if (cnt == CNT_LAST) begin
          state_nx = RUN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
        end
      end
      default: begin
        state_nx = WAIT_LOCK;
      end
    endcase
  end

  // Accumulators advance only on cycles where the FSM stays in RUN. On the
  // cycle RUN is being left, go is already low, so accumulators and
  // outputs clear on the same edge that drops run.
  assign go = (state == RUN) && lock_s;

  // Widened compare so the range check stays meaningful when NUM_CH is a
  // power of two.
  assign chan_ok = ({1'b0, cfg_chan} < (CH_W + 1)'(NUM_CH));

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !chan_ok;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_act;
    logic [ACC_W-1:0] inc_pend;
    logic             pend_v;
    logic             tick_r;
    logic             clk_r;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             wr_hit;
    logic             xfer;

    assign sum    = {1'b0, acc} + {1'b0, inc_act};
    assign carry  = go && sum[ACC_W];
    assign wr_hit = cfg_wr && chan_ok && (cfg_chan == CH_W'(c));

    // Adopt the pending increment at the end of the period in flight
    // (carry), or at once when the channel is not producing periods.
    assign xfer = pend_v && (carry || !go || (inc_act == '0));

    always_ff @(posedge clock_in) begin
      if (reset) begin
        acc      <= '0;
        inc_act  <= INC_INIT[c*ACC_W +: ACC_W];
        inc_pend <= INC_INIT[c*ACC_W +: ACC_W];
        pend_v   <= 1'b0;
        tick_r   <= 1'b0;
        clk_r    <= 1'b0;
      end else begin
        if (go) begin
          acc    <= sum[ACC_W-1:0];
          tick_r <= carry;
          clk_r  <= clk_r ^ carry;
        end else begin
          acc    <= '0;
          tick_r <= 1'b0;
          clk_r  <= 1'b0;
        end

        if (xfer) begin
          inc_act <= inc_pend;
          pend_v  <= 1'b0;
        end

        // A write coincident with a transfer stays pending: the transfer
        // above already consumed the previous pending value.
        if (wr_hit) begin
          inc_pend <= cfg_inc;
          pend_v   <= 1'b1;
        end
      end
    end

    assign tick[c]    = tick_r;
    assign clk_out[c] = clk_r;
  end

endmodule

// File: tb/tb_clock_enable_nco.sv
// ---------------------------------------------------------------------------
// tb_clock_enable_nco
//
// Directed bench for clock_enable_nco (NUM_CH=3, ACC_W=24, LOCK_WAIT=16,
// INC_INIT ch0=0x400000, ch1=ch2=0). Stimulus pushes the hand-derived
// cycle numbers of expected ticks (with the clk_out level after each tick)
// and of expected cfg_err pulses into queues; a negedge monitor pops and
// compares whenever the DUT shows a tick or cfg_err, and flags expected
// events whose cycle has passed. Channel 1 is counted rather than queued
// during the long fractional-rate run.
// ---------------------------------------------------------------------------
module tb_clock_enable_nco;

  localparam logic [71:0] INIT = {24'h000000, 24'h000000, 24'h400000};

  logic        clk;
  logic        reset;
  logic        locked;
  logic        cfg_wr;
  logic [1:0]  cfg_chan;
  logic [23:0] cfg_inc;
  logic        cfg_err;
  logic        run;
  logic [2:0]  tick;
  logic [2:0]  clk_out;

  clock_enable_nco #(
    .NUM_CH   (3),
    .ACC_W    (24),
    .INC_INIT (INIT),
    .LOCK_WAIT(16)
  ) dut (
    .clock_in(clk),
    .reset   (reset),
    .locked  (locked),
    .cfg_wr  (cfg_wr),
    .cfg_chan(cfg_chan),
    .cfg_inc (cfg_inc),
    .cfg_err (cfg_err),
    .run     (run),
    .tick    (tick),
    .clk_out (clk_out)
  );

  typedef struct packed {
    int   cyc;
    logic clk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   err_q[$];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] exp_clk = 3'b000;

  bit   cnt_mode = 0;
  int   frac_lo = 0;
  int   frac_hi = 0;
  int   frac_cnt = 0;
  int   adj_cnt = 0;
  int   last_t1 = -10;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int q_size(input int c);
    case (c)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_front(input int c);
    case (c)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic exp_t q_pop(input int c);
    case (c)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic push_ticks(input int c, input int first, input int period, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      exp_clk[c] = ~exp_clk[c];
      e.cyc = first + k * period;
      e.clk = exp_clk[c];
      case (c)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic mon_ch(input int c);
    exp_t e;
    bit   done;
    done = 0;
    while (!done) begin
      if (q_size(c) == 0) begin
        done = 1;
      end else begin
        e = q_front(c);
        if (e.cyc < cyc) begin
          e = q_pop(c);
          checks++;
          errors++;
          $display("FAIL tick_ch%0d: no tick seen, required one at cycle %0d", c, e.cyc);
        end else begin
          done = 1;
        end
      end
    end
    if (tick[c] === 1'b1) begin
      checks++;
      if (q_size(c) == 0) begin
        errors++;
        $display("FAIL tick_ch%0d: tick at cycle %0d, required none", c, cyc);
      end else begin
        e = q_pop(c);
        if (e.cyc != cyc || e.clk !== clk_out[c]) begin
          errors++;
          $display("FAIL tick_ch%0d: tick at cycle %0d clk_out=%0b, required cycle %0d clk_out=%0b",
                   c, cyc, clk_out[c], e.cyc, e.clk);
        end
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    mon_ch(0);
    if (cnt_mode) begin
      if (tick[1] === 1'b1 && cyc >= frac_lo && cyc <= frac_hi) begin
        frac_cnt++;
        if (last_t1 == cyc - 1) adj_cnt++;
        last_t1 = cyc;
      end
    end else begin
      mon_ch(1);
    end
    mon_ch(2);

    while (err_q.size() > 0 && err_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL cfg_err: no pulse seen, required one at cycle %0d", err_q.pop_front());
    end
    if (cfg_err === 1'b1) begin
      checks++;
      if (err_q.size() == 0 || err_q[0] != cyc) begin
        errors++;
        $display("FAIL cfg_err: pulse at cycle %0d, required none", cyc);
      end else begin
        void'(err_q.pop_front());
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [23:0] val, input int at);
    goto(at - 1);
    cfg_wr   = 1'b1;
    cfg_chan = ch;
    cfg_inc  = val;
    goto(at);
    cfg_wr   = 1'b0;
  endtask

  initial begin
    int  t0, t1, t2, x, y, z;
    longint exp_frac;

    reset    = 1'b1;
    locked   = 1'b0;
    cfg_wr   = 1'b0;
    cfg_chan = 2'd0;
    cfg_inc  = 24'h0;

    goto(3);
    chk("reset_run", {31'b0, run}, 32'd0);
    chk("reset_tick", {29'b0, tick}, 32'd0);
    chk("reset_clk_out", {29'b0, clk_out}, 32'd0);
    chk("reset_cfg_err", {31'b0, cfg_err}, 32'd0);
    reset = 1'b0;

    // Lock gating, retune sequence on ch0, ch2 off/on, bad channel.
    goto(13);
    locked = 1'b1;
    t0 = 13 + 19;
    push_ticks(0, t0 + 4, 4, 6);
    push_ticks(0, t0 + 32, 8, 3);
    push_ticks(0, t0 + 50, 2, 4);
    push_ticks(0, t0 + 60, 1, 1);
    push_ticks(0, t0 + 68, 8, 3);
    push_ticks(2, t0 + 93, 2, 3);
    push_ticks(2, t0 + 121, 16, 4);
    err_q.push_back(t0 + 110);

    goto(t0 - 1);
    chk("run_before_settle_done", {31'b0, run}, 32'd0);
    goto(t0);
    chk("run_after_settle", {31'b0, run}, 32'd1);

    wr(2'd0, 24'h200000, t0 + 22);
    wr(2'd0, 24'h800000, t0 + 44);
    wr(2'd0, 24'h400000, t0 + 55);
    wr(2'd0, 24'h200000, t0 + 56);
    wr(2'd0, 24'h000000, t0 + 80);
    wr(2'd2, 24'h800000, t0 + 90);
    wr(2'd2, 24'h000000, t0 + 96);
    wr(2'd2, 24'h100000, t0 + 104);
    wr(2'd3, 24'hFFFFFF, t0 + 110);

    goto(t0 + 170);
    chk("clk_out_levels", {29'b0, clk_out}, 32'h5);

    // Lock drop while running.
    x = t0 + 175;
    goto(x);
    locked = 1'b0;
    exp_clk = 3'b000;
    goto(x + 2);
    chk("run_two_after_drop", {31'b0, run}, 32'd1);
    goto(x + 3);
    chk("run_three_after_drop", {31'b0, run}, 32'd0);
    chk("tick_three_after_drop", {29'b0, tick}, 32'd0);
    chk("clk_out_three_after_drop", {29'b0, clk_out}, 32'd0);

    // One-cycle lock glitch during SETTLE restarts the settle interval.
    y = x + 6;
    goto(y);
    locked = 1'b1;
    goto(y + 5);
    locked = 1'b0;
    goto(y + 6);
    locked = 1'b1;
    t1 = y + 25;
    push_ticks(2, t1 + 16, 16, 3);
    goto(t1 - 1);
    chk("run_after_glitch_early", {31'b0, run}, 32'd0);
    goto(t1);
    chk("run_after_glitch", {31'b0, run}, 32'd1);
    wr(2'd2, 24'h000000, t1 + 40);

    // Fractional rate on ch1 over 2^16 adds.
    frac_lo  = t1 + 52;
    frac_hi  = t1 + 52 + 65535;
    cnt_mode = 1;
    wr(2'd1, 24'h0DF3B6, t1 + 50);
    goto(frac_hi + 2);
    exp_frac = (longint'(65536) * longint'(24'h0DF3B6)) >>> 24;
    checks++;
    if (longint'(frac_cnt) < exp_frac - 1 || longint'(frac_cnt) > exp_frac + 1) begin
      errors++;
      $display("FAIL frac_tick_count: got %0d, required %0d +/-1", frac_cnt, exp_frac);
    end
    chk("frac_adjacent_ticks", adj_cnt, 32'd0);

    // Reset with writes pending on all channels.
    z = frac_hi + 10;
    wr(2'd0, 24'h800000, z - 2);
    wr(2'd1, 24'h800000, z - 1);
    wr(2'd2, 24'h800000, z);
    reset = 1'b1;
    goto(z + 1);
    reset    = 1'b0;
    cnt_mode = 0;
    exp_clk  = 3'b000;
    chk("midreset_run", {31'b0, run}, 32'd0);
    chk("midreset_tick", {29'b0, tick}, 32'd0);
    chk("midreset_clk_out", {29'b0, clk_out}, 32'd0);
    t2 = z + 20;
    push_ticks(0, t2 + 4, 4, 4);
    goto(t2 - 1);
    chk("run_after_midreset_early", {31'b0, run}, 32'd0);
    goto(t2);
    chk("run_after_midreset", {31'b0, run}, 32'd1);
    goto(t2 + 20);

    chk("pending_ticks_ch0", q0.size(), 32'd0);
    chk("pending_ticks_ch1", q1.size(), 32'd0);
    chk("pending_ticks_ch2", q2.size(), 32'd0);
    chk("pending_cfg_err", err_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
